modmul_arbiter: RTL and testbench

- Shares one 256-bit modular multiplier (secp256k1 field, multiplier core `multiplier`) among NUM_REQ requesters: encryption, decryption, key generation and point arithmetic.
- Arbitrates round-robin, captures operands, restarts the core and waits for completion.
- Returns the product to the granted requester, or an error on timeout.
- Sits between the ECC top-level sequencers and the single multiplier instance.

---
 rtl/ecc_pkg.sv | 16 +
 rtl/rr_picker.sv | 33 +++
 rtl/modmul_arbiter.sv | 134 +++++++++++++
 tb/tb_modmul_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// Shared ECC datapath constants: secp256k1 field prime, default widths and
// the multiplier-arbiter state encoding.
package ecc_pkg;

    localparam int W_DEF       = 256;
    localparam int TIMEOUT_DEF = 1024;

    localparam logic [255:0] SECP256K1_P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_KICK = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin select: first set request at or after ptr_i,
// wrapping, as a one-hot grant plus its index.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IW-1:0]      idx_o,
    output logic               any_o
);

    // Scan from the farthest candidate back to ptr_i so the nearest one wins.
    always_comb begin
        int j;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = int'(ptr_i) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (req_i[IW'(j)]) begin
                gnt_o          = '0;
                gnt_o[IW'(j)]  = 1'b1;
                idx_o          = IW'(j);
                any_o          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/modmul_arbiter.sv
// Round-robin arbiter sharing one modular multiplier core between NUM_REQ
// requesters: accept, restart the core, wait for Done (or time out), respond.
module modmul_arbiter
    import ecc_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int W       = W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int IDW     = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*W-1:0] req_a,
    input  logic [NUM_REQ*W-1:0] req_b,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   resp_valid,
    output logic [W-1:0]         resp_data,
    output logic                 resp_err,
    output logic                 busy,
    output logic [IDW-1:0]       grant_id,
    output logic                 mul_clear,
    output logic [W-1:0]         mul_a,
    output logic [W-1:0]         mul_b,
    input  logic                 mul_done,
    input  logic [W-1:0]         mul_product
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] rr_q, rr_d;
    logic [IW-1:0] gnt_q, gnt_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  data_q, data_d;
    logic          err_q, err_d;

    logic [NUM_REQ-1:0]        pick_gnt;
    logic [IW-1:0]             pick_idx;
    logic                      pick_any;
    logic [NUM_REQ-1:0][W-1:0] a_arr, b_arr;

    assign a_arr = req_a;
    assign b_arr = req_b;

    rr_picker #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
        .req_i (req_valid),
        .ptr_i (rr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        gnt_d   = gnt_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    a_d     = a_arr[pick_idx];
                    b_d     = b_arr[pick_idx];
                    gnt_d   = pick_idx;
                    rr_d    = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                    state_d = ST_KICK;
                end
            end
            ST_KICK: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // First WAIT cycle may still see Done from the previous operation.
                if (cnt_q != '0 && mul_done) begin
                    data_d  = mul_product;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rr_q    <= '0;
            gnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        resp_valid = '0;
        if (state_q == ST_RESP) resp_valid[gnt_q] = 1'b1;
    end

    // Reset also holds the shared core in reset.
    assign mul_clear = rst | (state_q == ST_KICK);
    assign req_ready = (state_q == ST_IDLE && !rst) ? pick_gnt : '0;
    assign busy      = (state_q != ST_IDLE);
    assign grant_id  = IDW'(gnt_q);
    assign mul_a     = a_q;
    assign mul_b     = b_q;
    assign resp_data = data_q;
    assign resp_err  = err_q;

endmodule

// File: tb/tb_modmul_arbiter.sv
// Bench for modmul_arbiter: transaction-level reference model compared every
// cycle, a behavioural multiplier core, and directed scenario checks.
module tb_modmul_arbiter;
    import ecc_pkg::*;

    localparam int NR      = 4;
    localparam int W       = 256;
    localparam int IDW     = 3;
    localparam int TO_MAIN = 1024;
    localparam int TO_T    = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [NR-1:0]   req_valid, req_ready, resp_valid;
    logic [NR*W-1:0] req_a, req_b;
    logic [W-1:0]    resp_data, mul_a, mul_b, mul_product;
    logic            resp_err, busy, mul_clear, mul_done;
    logic [IDW-1:0]  grant_id;

    logic [NR-1:0]   t_req_valid, t_req_ready, t_resp_valid;
    logic [NR*W-1:0] t_req_a, t_req_b;
    logic [W-1:0]    t_resp_data, t_mul_a, t_mul_b;
    logic            t_resp_err, t_busy, t_mul_clear;
    logic [IDW-1:0]  t_grant_id;
    logic            t_mul_done = 1'b0;
    logic [W-1:0]    t_mul_product = '0;

    modmul_arbiter #(.NUM_REQ(NR), .W(W), .TIMEOUT(TO_MAIN), .IDW(IDW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_err(resp_err), .busy(busy), .grant_id(grant_id), .mul_clear(mul_clear),
        .mul_a(mul_a), .mul_b(mul_b), .mul_done(mul_done), .mul_product(mul_product)
    );

    modmul_arbiter #(.NUM_REQ(NR), .W(W), .TIMEOUT(TO_T), .IDW(IDW)) dut_t (
        .clk(clk), .rst(rst), .req_valid(t_req_valid), .req_a(t_req_a), .req_b(t_req_b),
        .req_ready(t_req_ready), .resp_valid(t_resp_valid), .resp_data(t_resp_data),
        .resp_err(t_resp_err), .busy(t_busy), .grant_id(t_grant_id), .mul_clear(t_mul_clear),
        .mul_a(t_mul_a), .mul_b(t_mul_b), .mul_done(t_mul_done), .mul_product(t_mul_product)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int pick(input logic [NR-1:0] v, input int p);
        for (int k = 0; k < NR; k++)
            if (v[(p + k) % NR]) return (p + k) % NR;
        return -1;
    endfunction

    function automatic int oh_idx(input logic [NR-1:0] v);
        for (int k = 0; k < NR; k++)
            if (v[k]) return k;
        return -1;
    endfunction

    function automatic logic [W-1:0] modp_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] t, r;
        t = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        r = t % {{W{1'b0}}, SECP256K1_P};
        return r[W-1:0];
    endfunction

    // Requesters and behavioural multiplier core.
    int           pend [NR];
    logic [W-1:0] a_val [NR];
    logic [W-1:0] b_val [NR];
    int           core_lat, core_cnt, t_pend;
    bit           core_stale, core_run;

    initial begin
        req_valid = '0; req_a = '0; req_b = '0;
        mul_done = 1'b0; mul_product = '0; core_run = 0; core_cnt = 0;
        t_req_valid = '0; t_req_a = '0; t_req_b = '0;
        forever begin
            logic [NR-1:0] rdy_s, t_rdy_s;
            logic          clr_s, rst_s;
            @(posedge clk);
            rdy_s = req_ready; t_rdy_s = t_req_ready; clr_s = mul_clear; rst_s = rst;
            #1;
            for (int i = 0; i < NR; i++)
                if (rdy_s[i] && pend[i] > 0) pend[i]--;
            if (t_rdy_s[3]) t_pend = 0;
            if (rst_s) begin
                core_run = 0;
                mul_done = 1'b0;
            end else if (clr_s) begin
                core_run = 1;
                core_cnt = core_lat;
                if (!core_stale) mul_done = 1'b0;
            end else if (core_run && core_cnt > 0) begin
                core_cnt--;
                if (core_cnt == 0) begin
                    mul_done    = 1'b1;
                    mul_product = modp_mul(mul_a, mul_b);
                end else begin
                    mul_done = 1'b0;
                end
            end
            for (int i = 0; i < NR; i++) begin
                req_valid[i]     = (pend[i] > 0);
                req_a[i*W +: W]  = a_val[i];
                req_b[i*W +: W]  = b_val[i];
            end
            t_req_valid = {(t_pend > 0), 3'b000};
        end
    end

    // Reference model: one transaction at a time, phase counted from accept.
    int           m_mode, m_owner, m_ptr, m_w;
    logic [W-1:0] m_a, m_b, m_data;
    logic         m_err;

    initial begin
        m_mode = 0; m_owner = 0; m_ptr = 0; m_w = 0;
        m_a = '0; m_b = '0; m_data = '0; m_err = 1'b0;
        forever begin
            int j;
            @(posedge clk);
            cyc++;
            if (rst) begin
                m_mode = 0; m_ptr = 0; m_owner = 0;
                m_a = '0; m_b = '0; m_data = '0; m_err = 1'b0;
            end else begin
                case (m_mode)
                    0: begin
                        j = pick(req_valid, m_ptr);
                        if (j >= 0) begin
                            m_owner = j;
                            m_a     = req_a[j*W +: W];
                            m_b     = req_b[j*W +: W];
                            m_ptr   = (j + 1) % NR;
                            m_mode  = 1;
                        end
                    end
                    1: begin m_mode = 2; m_w = 0; end
                    2: begin
                        if (m_w > 0 && mul_done) begin
                            m_data = mul_product; m_err = 1'b0; m_mode = 3;
                        end else if (m_w == TO_MAIN - 1) begin
                            m_data = '0; m_err = 1'b1; m_mode = 3;
                        end else begin
                            m_w++;
                        end
                    end
                    default: m_mode = 0;
                endcase
            end
        end
    end

    // Per-cycle compare against the model, plus transaction logs.
    int           gq_idx[$], gq_cyc[$], cq_cyc[$], rq_idx[$], rq_cyc[$];
    logic [W-1:0] rq_data[$];
    logic         rq_err[$];
    int           t_g_cyc = -1, t_c_cyc = -1, t_r_cyc = -1, t_r_idx = -1;
    logic [W-1:0] t_r_data;
    logic         t_r_err;

    initial forever begin
        logic [NR-1:0] er, ev;
        int            j;
        @(negedge clk);
        if (rst) begin
            chk("rst req_ready", W'(req_ready), '0);
            chk("rst resp_valid", W'(resp_valid), '0);
            chk("rst resp_data", resp_data, '0);
            chk("rst resp_err", W'(resp_err), '0);
            chk("rst busy", W'(busy), '0);
            chk("rst grant_id", W'(grant_id), '0);
            chk("rst mul_a", mul_a, '0);
            chk("rst mul_b", mul_b, '0);
            chk("rst mul_clear", W'(mul_clear), W'(1));
        end else begin
            er = '0; ev = '0;
            if (m_mode == 0) begin
                j = pick(req_valid, m_ptr);
                if (j >= 0) er[j] = 1'b1;
            end
            if (m_mode == 3) ev[m_owner] = 1'b1;
            chk("req_ready", W'(req_ready), W'(er));
            chk("resp_valid", W'(resp_valid), W'(ev));
            chk("busy", W'(busy), W'(m_mode != 0));
            chk("mul_clear", W'(mul_clear), W'(m_mode == 1));
            if (m_mode != 0) begin
                chk("grant_id", W'(grant_id), W'(m_owner));
                chk("mul_a", mul_a, m_a);
                chk("mul_b", mul_b, m_b);
            end
            if (m_mode == 3) begin
                chk("resp_data", resp_data, m_data);
                chk("resp_err", W'(resp_err), W'(m_err));
            end
            if (req_ready != '0) begin gq_idx.push_back(oh_idx(req_ready)); gq_cyc.push_back(cyc); end
            if (mul_clear) cq_cyc.push_back(cyc);
            if (resp_valid != '0) begin
                rq_idx.push_back(oh_idx(resp_valid)); rq_cyc.push_back(cyc);
                rq_data.push_back(resp_data); rq_err.push_back(resp_err);
            end
            if (t_req_ready != '0) t_g_cyc = cyc;
            if (t_mul_clear) t_c_cyc = cyc;
            if (t_resp_valid != '0) begin
                t_r_cyc = cyc; t_r_idx = oh_idx(t_resp_valid);
                t_r_data = t_resp_data; t_r_err = t_resp_err;
            end
        end
    end

    task automatic wait_resp(input int n, input int budget);
        int k;
        k = 0;
        while (rq_idx.size() < n && k < budget) begin @(negedge clk); #1; k++; end
        chki("wait resp count", rq_idx.size(), n);
    endtask

    task automatic wait_grant(input int n, input int budget);
        int k;
        k = 0;
        while (gq_idx.size() < n && k < budget) begin @(negedge clk); #1; k++; end
        chki("wait grant count", gq_idx.size(), n);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #1 rst = 1'b1;
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int g0, r0, c0, k;
        int exp_ord[5];
        rst = 1'b1; core_lat = 4; core_stale = 0; t_pend = 0;
        for (int i = 0; i < NR; i++) begin pend[i] = 0; a_val[i] = '0; b_val[i] = '0; end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset busy", W'(busy), '0);
        chk("reset mul_clear", W'(mul_clear), W'(1));
        chk("reset resp_valid", W'(resp_valid), '0);
        @(posedge clk); #1 rst = 1'b0;

        // Single request: 3*5 from requester 1, core latency 20.
        @(negedge clk);
        core_lat = 20; a_val[1] = W'(3); b_val[1] = W'(5);
        g0 = gq_idx.size(); r0 = rq_idx.size(); c0 = cq_cyc.size();
        pend[1] = 1;
        wait_resp(r0 + 1, 100);
        if (rq_idx.size() > r0 && gq_idx.size() > g0 && cq_cyc.size() > c0) begin
            chki("t1 grant idx", gq_idx[g0], 1);
            chki("t1 clear offset", cq_cyc[c0] - gq_cyc[g0], 1);
            chki("t1 resp idx", rq_idx[r0], 1);
            chk("t1 resp data", rq_data[r0], W'(15));
            chk("t1 resp err", W'(rq_err[r0]), '0);
            chki("t1 resp offset", rq_cyc[r0] - gq_cyc[g0], 23);
        end

        // Simultaneous 0101 from rr_ptr=0, then probe pointer with 1001.
        do_reset(2);
        @(negedge clk);
        core_lat = 3;
        a_val[0] = W'(4);  b_val[0] = W'(6);
        a_val[2] = W'(10); b_val[2] = W'(10);
        g0 = gq_idx.size(); r0 = rq_idx.size();
        pend[0] = 1; pend[2] = 1;
        wait_resp(r0 + 2, 100);
        if (rq_idx.size() >= r0 + 2) begin
            chki("t2 first grant", gq_idx[g0], 0);
            chki("t2 second grant", gq_idx[g0+1], 2);
            chk("t2 data 4*6", rq_data[r0], W'(24));
            chk("t2 data 10*10", rq_data[r0+1], W'(100));
        end
        @(negedge clk);
        a_val[3] = SECP256K1_P - 256'd1; b_val[3] = W'(2);
        g0 = gq_idx.size(); r0 = rq_idx.size();
        pend[0] = 1; pend[3] = 1;
        wait_resp(r0 + 2, 100);
        if (rq_idx.size() >= r0 + 2) begin
            chki("t2 ptr=3 grant", gq_idx[g0], 3);
            chki("t2 wrap grant", gq_idx[g0+1], 0);
            chk("t2 modular wrap", rq_data[r0], SECP256K1_P - 256'd2);
        end

        // Reset in the middle of WAIT: no response may follow.
        @(negedge clk);
        core_lat = 40; a_val[2] = W'(5); b_val[2] = W'(5);
        g0 = gq_idx.size();
        pend[2] = 1;
        wait_grant(g0 + 1, 50);
        repeat (5) @(negedge clk);
        chk("t3 busy in wait", W'(busy), W'(1));
        do_reset(2);
        r0 = rq_idx.size();
        repeat (10) @(negedge clk);
        chki("t3 no resp after abort", rq_idx.size(), r0);

        // Continuous contention from rr_ptr=0.
        @(negedge clk);
        core_lat = 2;
        for (int i = 0; i < NR; i++) begin a_val[i] = W'(i + 2); b_val[i] = W'(3); end
        g0 = gq_idx.size(); r0 = rq_idx.size();
        pend[0] = 2; pend[1] = 1; pend[2] = 1; pend[3] = 1;
        exp_ord = '{0, 1, 2, 3, 0};
        wait_resp(r0 + 5, 200);
        if (rq_idx.size() >= r0 + 5) begin
            for (k = 0; k < 5; k++) begin
                chki("t4 grant order", gq_idx[g0+k], exp_ord[k]);
                chki("t4 resp order", rq_idx[r0+k], exp_ord[k]);
            end
        end

        // Stale Done held through KICK and first WAIT cycle.
        @(negedge clk);
        core_lat = 6; core_stale = 1;
        a_val[1] = W'(7); b_val[1] = W'(11);
        a_val[3] = W'(2); b_val[3] = W'(9);
        g0 = gq_idx.size(); r0 = rq_idx.size();
        pend[1] = 1; pend[3] = 1;
        wait_resp(r0 + 2, 100);
        if (rq_idx.size() >= r0 + 2) begin
            chki("t5 grant a", gq_idx[g0], 1);
            chki("t5 grant b", gq_idx[g0+1], 3);
            chk("t5 data 7*11", rq_data[r0], W'(77));
            chk("t5 data 2*9", rq_data[r0+1], W'(18));
            chki("t5 offset a", rq_cyc[r0] - gq_cyc[g0], 9);
            chki("t5 offset b", rq_cyc[r0+1] - gq_cyc[g0+1], 9);
            chki("t5 back-to-back", gq_cyc[g0+1] - rq_cyc[r0], 1);
        end
        core_stale = 0;

        // Timeout instance: Done never arrives.
        @(negedge clk);
        t_pend = 1;
        k = 0;
        while (t_r_cyc < 0 && k < 100) begin @(negedge clk); #1; k++; end
        chki("t6 resp seen", (t_r_cyc >= 0) ? 1 : 0, 1);
        if (t_r_cyc >= 0) begin
            chki("t6 clear offset", t_c_cyc - t_g_cyc, 1);
            chki("t6 resp after WAIT entry", t_r_cyc - (t_g_cyc + 2), 16);
            chki("t6 resp idx", t_r_idx, 3);
            chk("t6 resp err", W'(t_r_err), W'(1));
            chk("t6 resp data", t_r_data, '0);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

endmodule
